// File: rtl/reg_write_initiator_pkg.sv
// Shared register-file definitions: default widths, the hardwired zero register
// index, and the write-back queue entry layout. The register file and hazard
// unit import the same package so all three agree on these widths.
package reg_write_initiator_pkg;

  localparam int unsigned RF_DATA_W = 8;   // register data width
  localparam int unsigned RF_ADDR_W = 5;   // register index width (32 registers)
  localparam int unsigned WBQ_DEPTH = 4;   // write-back queue entries
  localparam int unsigned ZERO_REG  = 0;   // index that is never written

  // One queued register write, data mux already resolved.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] dest;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_initiator_wb_queue.sv
// wb_queue: circular in-order FIFO of pending register writes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_dest/data enqueue one entry (caller guarantees not full)
//   pop                 dequeue head (caller guarantees not empty)
//   count, rd_ptr       occupancy and physical head slot
//   next_dest/data      entry one behind the head (the head after a pop)
//   slot_data           raw data of every physical slot
//   q1/q2_point         source indices to search
//   q1/q2_match         per physical slot: slot valid and dest matches
module wb_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_dest,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [ADDR_W-1:0] next_dest,
  output logic [DATA_W-1:0] next_data,
  output logic [DATA_W-1:0] slot_data [DEPTH],
  input  logic [ADDR_W-1:0] q1_point,
  input  logic [ADDR_W-1:0] q2_point,
  output logic [DEPTH-1:0]  q1_match,
  output logic [DEPTH-1:0]  q2_match
);

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_next;
  logic [DEPTH-1:0]  valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: validity is derived from pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= push_dest;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid    = '0;
    q1_match = '0;
    q2_match = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      valid[s]    = {1'b0, PTR_W'(s) - rd_ptr_q} < count_q;
      q1_match[s] = valid[s] && (dest_mem[s] == q1_point);
      q2_match[s] = valid[s] && (dest_mem[s] == q2_point);
      slot_data[s] = data_mem[s];
    end
  end

  assign rd_next   = rd_ptr_q + PTR_W'(1);
  assign next_dest = dest_mem[rd_next];
  assign next_data = data_mem[rd_next];
  assign count     = count_q;
  assign rd_ptr    = rd_ptr_q;

endmodule

// File: rtl/reg_write_initiator.sv
// reg_write_initiator: buffers completed results from MEM/WB and drives the
// register file's single write port, one entry per granted cycle, while
// exposing a pending-write scoreboard with forwarding data for decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        result handshake (ready = count < DEPTH)
//   in_reg_write, in_dest    write qualifier and destination index
//   in_mem_to_reg            selects in_mem_data over in_alu_data
//   wr_grant                 register file port available
//   wr_enable/point/data     registered write request (view of queue head)
//   q1/q2_point              decode source indices
//   q1/q2_pending, q1/q2_fwd queued-write hit and youngest matching data
//   count                    queued entries
module reg_write_initiator
  import reg_write_initiator_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = WBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_reg_write,
  input  logic                     in_mem_to_reg,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [DATA_W-1:0]        in_alu_data,
  input  logic [DATA_W-1:0]        in_mem_data,
  input  logic                     wr_grant,
  output logic                     wr_enable,
  output logic [ADDR_W-1:0]        wr_point,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        q1_point,
  input  logic [ADDR_W-1:0]        q2_point,
  output logic                     q1_pending,
  output logic                     q2_pending,
  output logic [DATA_W-1:0]        q1_fwd,
  output logic [DATA_W-1:0]        q2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] next_dest;
  logic [DATA_W-1:0] next_data;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  q1_match;
  logic [DEPTH-1:0]  q2_match;
  logic [DATA_W:0]   q1_hit;
  logic [DATA_W:0]   q2_hit;

  assign in_ready  = count < CNT_W'(DEPTH);
  assign push_data = in_mem_to_reg ? in_mem_data : in_alu_data;
  // Writes to the zero register and non-writing results are consumed silently.
  assign push = in_valid && in_ready && in_reg_write && (in_dest != ADDR_W'(ZERO_REG));
  assign pop  = wr_enable && wr_grant;

  wb_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dest (in_dest),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .next_dest (next_dest),
    .next_data (next_data),
    .slot_data (slot_data),
    .q1_point  (q1_point),
    .q2_point  (q2_point),
    .q1_match  (q1_match),
    .q2_match  (q2_match)
  );

  // The write port registers track the head the queue will have after this
  // edge: the entry behind the head on a pop, the incoming entry when it
  // lands in an empty (or just-emptied) queue, otherwise the current head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_enable <= 1'b0;
      wr_point  <= '0;
      wr_data   <= '0;
    end else if (pop) begin
      if (count > CNT_W'(1)) begin
        wr_enable <= 1'b1;
        wr_point  <= next_dest;
        wr_data   <= next_data;
      end else if (push) begin
        wr_enable <= 1'b1;
        wr_point  <= in_dest;
        wr_data   <= push_data;
      end else begin
        wr_enable <= 1'b0;
      end
    end else if (push && count == '0) begin
      wr_enable <= 1'b1;
      wr_point  <= in_dest;
      wr_data   <= push_data;
    end
  end

  // Walk slots oldest to youngest so the last hit is the youngest write.
  function automatic logic [DATA_W:0] youngest(
    input logic [DEPTH-1:0]  match,
    input logic [PTR_W-1:0]  head,
    input logic [DATA_W-1:0] data [DEPTH]
  );
    logic [DATA_W:0]  r;
    logic [PTR_W-1:0] idx;
    r = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (match[idx]) r = {1'b1, data[idx]};
    end
    return r;
  endfunction

  always_comb begin
    q1_hit     = youngest(q1_match, rd_ptr, slot_data);
    q2_hit     = youngest(q2_match, rd_ptr, slot_data);
    q1_pending = q1_hit[DATA_W] && (q1_point != ADDR_W'(ZERO_REG));
    q2_pending = q2_hit[DATA_W] && (q2_point != ADDR_W'(ZERO_REG));
    q1_fwd     = q1_pending ? q1_hit[DATA_W-1:0] : '0;
    q2_fwd     = q2_pending ? q2_hit[DATA_W-1:0] : '0;
  end

endmodule
